l2_arbiter: RTL and testbench

- Two-client arbiter between the L1 caches (icache, dcache) and the single L2 request port.
- Sits directly downstream of the dcache's l2_* interface and upstream of L2.
- Grants one client at a time using round-robin priority.
- Captures the granted request into registers, drives L2 until l2_req_fulfilled, then routes the fulfilment and fetched word back to the granted client.

---
 rtl/xentry_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/l2_arbiter.sv | 105 ++++++++++
 tb/tb_l2_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xentry_pkg.sv
// Shared types for the L1/L2 memory path: memory operations, arbiter
// states and L2 client identifiers.
package xentry_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        STORE = 2'd1
    } memory_operation_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IC = 2'd1,
        GRANT_DC = 2'd2
    } arb_state_e;

    typedef enum logic {
        CLIENT_IC = 1'b0,
        CLIENT_DC = 1'b1
    } l2_client_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin priority: req[0] is the icache, req[1] the dcache.
// last_grant moves to advance_client when the owning transaction completes.
module rr_arbiter2
    import xentry_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    input  l2_client_e advance_client,
    output logic [1:0] grant,
    output l2_client_e last_grant
);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= CLIENT_IC;
        end else if (advance) begin
            last_grant <= advance_client;
        end
    end

    // On a tie the client that did not win last time goes first.
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == CLIENT_IC) ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates the icache and dcache onto the single L2 request port, holds the
// captured request until L2 fulfils it, and routes the reply to the owner.
module l2_arbiter
    import xentry_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   ic_req_address,
    input  memory_operation_e ic_req_type,
    input  logic              ic_req_valid,
    input  logic [XLEN-1:0]   ic_word_to_store,
    output logic [XLEN-1:0]   ic_fetched_word,
    output logic              ic_req_fulfilled,
    input  logic [XLEN-1:0]   dc_req_address,
    input  memory_operation_e dc_req_type,
    input  logic              dc_req_valid,
    input  logic [XLEN-1:0]   dc_word_to_store,
    output logic [XLEN-1:0]   dc_fetched_word,
    output logic              dc_req_fulfilled,
    output logic [XLEN-1:0]   l2_req_address,
    output memory_operation_e l2_req_type,
    output logic              l2_req_valid,
    output logic [XLEN-1:0]   l2_word_to_store,
    input  logic [XLEN-1:0]   l2_fetched_word,
    input  logic              l2_req_fulfilled
);

    arb_state_e state;
    arb_state_e state_next;
    logic [1:0] grant;
    logic       advance;
    logic       capture_ic;
    logic       capture_dc;
    l2_client_e advance_client;
    l2_client_e last_grant;

    rr_arbiter2 u_rr (
        .clk            (clk),
        .reset          (reset),
        .req            ({dc_req_valid, ic_req_valid}),
        .advance        (advance),
        .advance_client (advance_client),
        .grant          (grant),
        .last_grant     (last_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            l2_req_address   <= '0;
            l2_req_type      <= LOAD;
            l2_word_to_store <= '0;
        end else begin
            state <= state_next;
            if (capture_ic) begin
                l2_req_address   <= ic_req_address;
                l2_req_type      <= ic_req_type;
                l2_word_to_store <= ic_word_to_store;
            end else if (capture_dc) begin
                l2_req_address   <= dc_req_address;
                l2_req_type      <= dc_req_type;
                l2_word_to_store <= dc_word_to_store;
            end
        end
    end

    always_comb begin
        state_next = state;
        capture_ic = 1'b0;
        capture_dc = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (grant[0]) begin
                    capture_ic = 1'b1;
                    state_next = GRANT_IC;
                end else if (grant[1]) begin
                    capture_dc = 1'b1;
                    state_next = GRANT_DC;
                end
            end
            GRANT_IC, GRANT_DC: begin
                // Client valid is ignored here: the L2 transaction is in flight.
                if (l2_req_fulfilled) begin
                    advance    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign advance_client   = (state == GRANT_DC) ? CLIENT_DC : CLIENT_IC;
    assign l2_req_valid     = (state != IDLE);
    assign ic_req_fulfilled = l2_req_fulfilled && (state == GRANT_IC);
    assign dc_req_fulfilled = l2_req_fulfilled && (state == GRANT_DC);
    assign ic_fetched_word  = l2_fetched_word;
    assign dc_fetched_word  = l2_fetched_word;

    a_icache_priority: assert property (@(posedge clk) disable iff (reset)
        (state == GRANT_IC && l2_req_fulfilled) |=> (last_grant == CLIENT_IC));

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: stimulus pushes expected L2 requests and
// client replies; a monitor compares them as the DUT presents them.
module tb_l2_arbiter;
    import xentry_pkg::*;

    localparam int unsigned XLEN = 32;

    typedef struct {
        logic [XLEN-1:0]   addr;
        memory_operation_e typ;
        logic [XLEN-1:0]   word;
    } req_t;

    typedef struct {
        l2_client_e      client;
        logic [XLEN-1:0] data;
    } resp_t;

    logic              clk;
    logic              reset;
    logic [XLEN-1:0]   ic_req_address;
    memory_operation_e ic_req_type;
    logic              ic_req_valid;
    logic [XLEN-1:0]   ic_word_to_store;
    logic [XLEN-1:0]   ic_fetched_word;
    logic              ic_req_fulfilled;
    logic [XLEN-1:0]   dc_req_address;
    memory_operation_e dc_req_type;
    logic              dc_req_valid;
    logic [XLEN-1:0]   dc_word_to_store;
    logic [XLEN-1:0]   dc_fetched_word;
    logic              dc_req_fulfilled;
    logic [XLEN-1:0]   l2_req_address;
    memory_operation_e l2_req_type;
    logic              l2_req_valid;
    logic [XLEN-1:0]   l2_word_to_store;
    logic [XLEN-1:0]   l2_fetched_word;
    logic              l2_req_fulfilled;

    logic              auto_ful;
    logic [XLEN-1:0]   auto_data;
    logic              man_ful;
    logic [XLEN-1:0]   man_data;
    logic              l2_auto;
    int                fixed_lat;

    int                checks;
    int                errors;
    req_t              exp_req[$];
    resp_t             exp_resp[$];

    assign l2_req_fulfilled = auto_ful | man_ful;
    assign l2_fetched_word  = auto_ful ? auto_data : man_data;

    l2_arbiter #(.XLEN(XLEN)) dut (
        .clk              (clk),
        .reset            (reset),
        .ic_req_address   (ic_req_address),
        .ic_req_type      (ic_req_type),
        .ic_req_valid     (ic_req_valid),
        .ic_word_to_store (ic_word_to_store),
        .ic_fetched_word  (ic_fetched_word),
        .ic_req_fulfilled (ic_req_fulfilled),
        .dc_req_address   (dc_req_address),
        .dc_req_type      (dc_req_type),
        .dc_req_valid     (dc_req_valid),
        .dc_word_to_store (dc_word_to_store),
        .dc_fetched_word  (dc_fetched_word),
        .dc_req_fulfilled (dc_req_fulfilled),
        .l2_req_address   (l2_req_address),
        .l2_req_type      (l2_req_type),
        .l2_req_valid     (l2_req_valid),
        .l2_word_to_store (l2_word_to_store),
        .l2_fetched_word  (l2_fetched_word),
        .l2_req_fulfilled (l2_req_fulfilled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // L2 memory contents: 0x1040 maps to 0xDEADBEEF.
    function automatic logic [XLEN-1:0] data_of(input logic [XLEN-1:0] a);
        return a + 32'hDEAD_AEAF;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [XLEN-1:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h with nothing expected at %0t", name, act, $time);
    endtask

    task automatic expect_txn(input l2_client_e c, input logic [XLEN-1:0] a,
                              input memory_operation_e t, input logic [XLEN-1:0] w);
        req_t  r;
        resp_t p;
        r.addr = a; r.typ = t; r.word = w;
        p.client = c; p.data = data_of(a);
        exp_req.push_back(r);
        exp_resp.push_back(p);
    endtask

    task automatic drive(input l2_client_e c, input logic [XLEN-1:0] a,
                         input memory_operation_e t, input logic [XLEN-1:0] w,
                         input logic v);
        if (c == CLIENT_IC) begin
            ic_req_address = a; ic_req_type = t; ic_word_to_store = w; ic_req_valid = v;
        end else begin
            dc_req_address = a; dc_req_type = t; dc_word_to_store = w; dc_req_valid = v;
        end
    endtask

    task automatic drop_valid(input l2_client_e c);
        if (c == CLIENT_IC) ic_req_valid = 1'b0;
        else                dc_req_valid = 1'b0;
    endtask

    task automatic wait_ful(input l2_client_e c);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (c == CLIENT_IC) ? ic_req_fulfilled : dc_req_fulfilled;
        end
        check(c == CLIENT_IC ? "ic fulfil within budget" : "dc fulfil within budget",
              {31'b0, seen}, 32'd1);
    endtask

    task automatic client_run(input l2_client_e c, input logic [XLEN-1:0] a,
                              input memory_operation_e t, input logic [XLEN-1:0] w,
                              input int n);
        drive(c, a, t, w, 1'b1);
        for (int k = 0; k < n; k++) wait_ful(c);
        @(posedge clk); #1;
        drop_valid(c);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic monitor();
        logic  prev_valid;
        req_t  cur;
        resp_t e;
        prev_valid = 1'b0;
        cur.addr = '0; cur.typ = LOAD; cur.word = '0;
        forever begin
            @(negedge clk);
            if (l2_req_valid && !prev_valid) begin
                if (exp_req.size() == 0) fail("unexpected l2 request", l2_req_address);
                else cur = exp_req.pop_front();
            end
            if (l2_req_valid) begin
                check("l2_req_address", l2_req_address, cur.addr);
                check("l2_req_type", 32'(l2_req_type), 32'(cur.typ));
                check("l2_word_to_store", l2_word_to_store, cur.word);
            end
            prev_valid = l2_req_valid;
            if (ic_req_fulfilled && dc_req_fulfilled) begin
                fail("both clients fulfilled", 32'd3);
            end else if (ic_req_fulfilled || dc_req_fulfilled) begin
                if (exp_resp.size() == 0) begin
                    fail("unexpected fulfil", {31'b0, dc_req_fulfilled});
                end else begin
                    e = exp_resp.pop_front();
                    check("fulfilled client", {31'b0, dc_req_fulfilled}, 32'(e.client));
                    check("fetched word",
                          dc_req_fulfilled ? dc_fetched_word : ic_fetched_word, e.data);
                end
            end
        end
    endtask

    // L2 model: answers each request after fixed_lat cycles, or 1..20 if zero.
    initial begin
        int lat;
        auto_ful  = 1'b0;
        auto_data = '0;
        forever begin
            @(posedge clk); #1;
            if (l2_auto && l2_req_valid) begin
                if (fixed_lat != 0) lat = fixed_lat;
                else                lat = int'($urandom_range(1, 20));
                repeat (lat - 1) begin
                    @(posedge clk); #1;
                end
                auto_data = data_of(l2_req_address);
                auto_ful  = 1'b1;
                @(posedge clk); #1;
                auto_ful  = 1'b0;
                auto_data = '0;
            end
        end
    end

    initial begin
        l2_client_e first;
        l2_client_e second;
        l2_client_e c;
        l2_client_e model_last;
        logic [XLEN-1:0] a1;
        logic [XLEN-1:0] a2;
        int n;

        checks = 0;
        errors = 0;
        reset = 1'b1;
        ic_req_address = '0; ic_req_type = LOAD; ic_req_valid = 1'b0; ic_word_to_store = '0;
        dc_req_address = '0; dc_req_type = LOAD; dc_req_valid = 1'b0; dc_word_to_store = '0;
        man_ful = 1'b0; man_data = '0;
        l2_auto = 1'b1; fixed_lat = 3;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("reset l2_req_valid", {31'b0, l2_req_valid}, 32'd0);
        check("reset l2_req_address", l2_req_address, 32'd0);
        check("reset l2_req_type", 32'(l2_req_type), 32'd0);
        check("reset l2_word_to_store", l2_word_to_store, 32'd0);
        reset = 1'b0;

        // Single dcache load, one-cycle grant latency.
        expect_txn(CLIENT_DC, 32'h0000_1040, LOAD, 32'h0);
        drive(CLIENT_DC, 32'h0000_1040, LOAD, 32'h0, 1'b1);
        @(negedge clk);
        check("valid low in sample cycle", {31'b0, l2_req_valid}, 32'd0);
        @(negedge clk);
        check("valid high next cycle", {31'b0, l2_req_valid}, 32'd1);
        wait_ful(CLIENT_DC);
        check("ic_req_fulfilled during dc reply", {31'b0, ic_req_fulfilled}, 32'd0);
        check("dc_fetched_word", dc_fetched_word, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        drop_valid(CLIENT_DC);

        // Both held after reset: dc, ic, dc, ic.
        do_reset();
        expect_txn(CLIENT_DC, 32'h3000, STORE, 32'h2222_2222);
        expect_txn(CLIENT_IC, 32'h2000, LOAD,  32'h1111_1111);
        expect_txn(CLIENT_DC, 32'h3000, STORE, 32'h2222_2222);
        expect_txn(CLIENT_IC, 32'h2000, LOAD,  32'h1111_1111);
        fork
            client_run(CLIENT_IC, 32'h2000, LOAD,  32'h1111_1111, 2);
            client_run(CLIENT_DC, 32'h3000, STORE, 32'h2222_2222, 2);
        join

        // dcache store with inputs scrambled mid-grant.
        fixed_lat = 5;
        expect_txn(CLIENT_DC, 32'h44, STORE, 32'hA5A5_A5A5);
        drive(CLIENT_DC, 32'h44, STORE, 32'hA5A5_A5A5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        drive(CLIENT_DC, 32'hFFFF_FFF0, LOAD, 32'h1234_5678, 1'b1);
        drive(CLIENT_IC, 32'h0BAD_0000, STORE, 32'h0BAD_0001, 1'b0);
        wait_ful(CLIENT_DC);
        @(posedge clk); #1;
        drop_valid(CLIENT_DC);

        // Stray fulfil while idle.
        man_data = 32'hBAD0_BAD0;
        man_ful  = 1'b1;
        @(negedge clk);
        check("idle stray ic_req_fulfilled", {31'b0, ic_req_fulfilled}, 32'd0);
        check("idle stray dc_req_fulfilled", {31'b0, dc_req_fulfilled}, 32'd0);
        @(posedge clk); #1;
        man_ful = 1'b0;
        check("idle stray stays idle", {31'b0, l2_req_valid}, 32'd0);
        expect_txn(CLIENT_IC, 32'h600, LOAD, 32'h0);
        client_run(CLIENT_IC, 32'h600, LOAD, 32'h0, 1);

        // Reset two cycles into GRANT_IC, then a late fulfil.
        l2_auto = 1'b0;
        begin
            req_t r;
            r.addr = 32'h5000; r.typ = LOAD; r.word = 32'h77;
            exp_req.push_back(r);
        end
        drive(CLIENT_IC, 32'h5000, LOAD, 32'h77, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        drop_valid(CLIENT_IC);
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset mid-grant l2_req_valid", {31'b0, l2_req_valid}, 32'd0);
        check("reset mid-grant l2_req_address", l2_req_address, 32'd0);
        check("reset mid-grant l2_word_to_store", l2_word_to_store, 32'd0);
        man_data = 32'hFEED_F00D;
        man_ful  = 1'b1;
        @(negedge clk);
        check("late fulfil ic_req_fulfilled", {31'b0, ic_req_fulfilled}, 32'd0);
        check("late fulfil dc_req_fulfilled", {31'b0, dc_req_fulfilled}, 32'd0);
        @(posedge clk); #1;
        man_ful = 1'b0;
        check("late fulfil stays idle", {31'b0, l2_req_valid}, 32'd0);
        l2_auto = 1'b1;

        // 1000 requests with random L2 latency; ties follow the bench's own rotation.
        fixed_lat  = 0;
        do_reset();
        model_last = CLIENT_IC;
        n = 0;
        while (n < 1000) begin
            a1 = {$urandom_range(0, 32'hFFFF), 2'b00, 14'h0} | 32'($urandom_range(0, 255) * 4);
            a2 = a1 ^ 32'h0001_0000;
            if ($urandom_range(0, 2) == 0) begin
                first  = (model_last == CLIENT_IC) ? CLIENT_DC : CLIENT_IC;
                second = (first == CLIENT_IC) ? CLIENT_DC : CLIENT_IC;
                expect_txn(first,  a1, STORE, ~a1);
                expect_txn(second, a2, LOAD,  a2);
                fork
                    client_run(first,  a1, STORE, ~a1, 1);
                    client_run(second, a2, LOAD,  a2, 1);
                join
                model_last = second;
                n += 2;
            end else begin
                c = l2_client_e'($urandom_range(0, 1));
                expect_txn(c, a1, memory_operation_e'($urandom_range(0, 1)), a2);
                client_run(c, a1, exp_req[exp_req.size() - 1].typ, a2, 1);
                model_last = c;
                n += 1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("request queue drained", 32'(exp_req.size()), 32'd0);
        check("response queue drained", 32'(exp_resp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
